// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between a core request port and a
// single-ported word memory with a fixed multi-cycle read delay.
// Build option: define MAU_RMW_EN to service misaligned sub-word stores by
// read-modify-write. Without it those stores complete as errors.
module mem_access_unit #(
    parameter int unsigned READ_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_write_data_src,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT - 1);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [1:0] SRC_WORD = 2'b00;
    localparam logic [1:0] SRC_BYTE = 2'b01;
    localparam logic [1:0] SRC_HALF = 2'b10;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
`ifdef MAU_RMW_EN
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
`endif
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       lat_size, lat_size_n;
    logic             lat_uns, lat_uns_n;
    logic [1:0]       lat_off, lat_off_n;
`ifdef MAU_RMW_EN
    logic [15:0]      lat_wdata, lat_wdata_n;
`endif
    logic             ack_n, err_n, mem_read_n, mem_write_n;
    logic [31:0]      rdata_n, mem_addr_n, mem_write_data_n;
    logic [1:0]       src_n;
    logic             req_bad, req_in_lane;

    // Extract the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

`ifdef MAU_RMW_EN
    // Replace the target lane(s) of a read word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic [15:0] d);
        logic [31:0] m;
        m = w;
        if (sz == SZ_HALF) begin
            if (off[1]) m[31:16] = d;
            else        m[15:0]  = d;
        end else begin
            m[8*off +: 8] = d[7:0];
        end
        store_merge = m;
    endfunction
`endif

    // Classify the incoming request: illegal size/alignment, or in-lane access.
    always_comb begin
        req_bad     = (size == 2'b11) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                      ((size == SZ_HALF) && addr[0]);
        req_in_lane = (size == SZ_WORD) || (addr[1:0] == 2'b00);
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        lat_size_n       = lat_size;
        lat_uns_n        = lat_uns;
        lat_off_n        = lat_off;
`ifdef MAU_RMW_EN
        lat_wdata_n      = lat_wdata;
`endif
        ack_n            = 1'b0;
        mem_read_n       = 1'b0;
        mem_write_n      = 1'b0;
        err_n            = err;
        rdata_n          = rdata;
        mem_addr_n       = mem_addr;
        mem_write_data_n = mem_write_data;
        src_n            = mem_write_data_src;

        case (state)
            IDLE: begin
                if (req) begin
                    lat_size_n = size;
                    lat_uns_n  = unsigned_ld;
                    lat_off_n  = addr[1:0];
`ifdef MAU_RMW_EN
                    lat_wdata_n = wdata[15:0];
`endif
                    mem_addr_n = {addr[31:2], 2'b00};
                    if (req_bad) begin
                        state_n = DONE;
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
                    end else if (!we) begin
                        state_n    = RD;
                        mem_read_n = 1'b1;
                        cnt_n      = '0;
                    end else if (req_in_lane) begin
                        state_n          = WR;
                        mem_write_n      = 1'b1;
                        mem_write_data_n = wdata;
                        case (size)
                            SZ_BYTE: src_n = SRC_BYTE;
                            SZ_HALF: src_n = SRC_HALF;
                            default: src_n = SRC_WORD;
                        endcase
                    end else begin
`ifdef MAU_RMW_EN
                        state_n    = RMW_RD;
                        mem_read_n = 1'b1;
                        cnt_n      = '0;
`else
                        state_n = DONE;
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
`endif
                    end
                end
            end
            RD: begin
                if (cnt == CNT_LAST) begin
                    rdata_n = load_extract(mem_read_data, lat_size, lat_off, lat_uns);
                    err_n   = 1'b0;
                    ack_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    mem_read_n = 1'b1;
                    cnt_n      = cnt + CNT_W'(1);
                end
            end
            WR: begin
                err_n   = 1'b0;
                ack_n   = 1'b1;
                state_n = DONE;
            end
`ifdef MAU_RMW_EN
            RMW_RD: begin
                if (cnt == CNT_LAST) begin
                    mem_write_data_n = store_merge(mem_read_data, lat_size, lat_off, lat_wdata);
                    src_n            = SRC_WORD;
                    mem_write_n      = 1'b1;
                    state_n          = RMW_WR;
                end else begin
                    mem_read_n = 1'b1;
                    cnt_n      = cnt + CNT_W'(1);
                end
            end
            RMW_WR: begin
                err_n   = 1'b0;
                ack_n   = 1'b1;
                state_n = DONE;
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, request context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            lat_size           <= SZ_WORD;
            lat_uns            <= 1'b0;
            lat_off            <= 2'b00;
`ifdef MAU_RMW_EN
            lat_wdata          <= '0;
`endif
            ack                <= 1'b0;
            err                <= 1'b0;
            mem_read           <= 1'b0;
            mem_write          <= 1'b0;
            rdata              <= '0;
            mem_addr           <= '0;
            mem_write_data     <= '0;
            mem_write_data_src <= SRC_WORD;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            lat_size           <= lat_size_n;
            lat_uns            <= lat_uns_n;
            lat_off            <= lat_off_n;
`ifdef MAU_RMW_EN
            lat_wdata          <= lat_wdata_n;
`endif
            ack                <= ack_n;
            err                <= err_n;
            mem_read           <= mem_read_n;
            mem_write          <= mem_write_n;
            rdata              <= rdata_n;
            mem_addr           <= mem_addr_n;
            mem_write_data     <= mem_write_data_n;
            mem_write_data_src <= src_n;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int unsigned RW = 3;
`ifdef MAU_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ack, err, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_write_data, mem_read_data;
    logic [1:0]  mem_write_data_src;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata_hold;
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_access_unit #(.READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_write_data_src(mem_write_data_src),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[5:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: model the expected outcome, drive it, watch the memory side.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        int unsigned off, exp_lat, exp_rd, exp_wr, cyc, n_rd, n_wr, n_ovl, n_badaddr;
        logic [3:0]  idx;
        logic [31:0] old, lane, exp_rdata, newv, exp_wd, seen_wd;
        logic [1:0]  exp_src, seen_src;
        bit          bad, misal;

        off   = int'(a[1:0]);
        idx   = a[5:2];
        bad   = (sz == 2'd3) || (sz == 2'd0 && off != 0) || (sz == 2'd2 && off % 2 != 0);
        misal = w && !bad && sz != 2'd0 && off != 0;
        if (misal && !RMW) bad = 1'b1;
        exp_lat = bad ? 1 : (!w ? RW + 1 : (misal ? RW + 2 : 2));
        exp_rd  = (!bad && (!w || misal)) ? RW : 0;
        exp_wr  = (!bad && w) ? 1 : 0;

        old  = ref_mem[idx];
        lane = old >> (8 * off);
        exp_rdata = old;
        if (sz == 2'd1) begin
            exp_rdata = lane & 32'hFF;
            if (!u && exp_rdata >= 32'h80) exp_rdata = exp_rdata | 32'hFFFF_FF00;
        end else if (sz == 2'd2) begin
            exp_rdata = lane & 32'hFFFF;
            if (!u && exp_rdata >= 32'h8000) exp_rdata = exp_rdata | 32'hFFFF_0000;
        end

        newv = old;
        if (exp_wr == 1) begin
            if (sz == 2'd0)      newv = d;
            else if (sz == 2'd1) newv = (old & ~(32'hFF << (8 * off))) | ((d & 32'hFF) << (8 * off));
            else                 newv = (old & ~(32'hFFFF << (8 * off))) | ((d & 32'hFFFF) << (8 * off));
            ref_mem[idx] = newv;
        end
        exp_src = misal ? 2'd0 : sz;
        exp_wd  = misal ? newv : d;

        req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cyc = 1; n_rd = 0; n_wr = 0; n_ovl = 0; n_badaddr = 0;
        seen_wd = 32'h0; seen_src = 2'd3;
        forever begin
            if (mem_read && mem_write) n_ovl++;
            if ((mem_read || mem_write) && mem_addr !== {a[31:2], 2'b00}) n_badaddr++;
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                seen_wd  = mem_write_data;
                seen_src = mem_write_data_src;
                case (mem_write_data_src)
                    2'd1:    mem[mem_addr[5:2]][7:0]  = mem_write_data[7:0];
                    2'd2:    mem[mem_addr[5:2]][15:0] = mem_write_data[15:0];
                    default: mem[mem_addr[5:2]]       = mem_write_data;
                endcase
            end
            if (ack) break;
            if (cyc >= 20) begin
                check("ack_timeout", 32'(cyc), 32'(exp_lat));
                break;
            end
            // Busy: the unit must ignore whatever appears on the request port.
            req = 1'b1; we = 1'($urandom); size = 2'($urandom);
            addr = $urandom; wdata = $urandom; unsigned_ld = 1'($urandom);
            @(posedge clk);
            #1;
            cyc++;
        end
        req = 1'b0;
        if (!bad && !w) exp_rdata_hold = exp_rdata;

        check("latency", 32'(cyc), 32'(exp_lat));
        check("err", 32'(err), 32'(bad));
        check("rdata", rdata, exp_rdata_hold);
        check("mem_rw_in_done", 32'(mem_read | mem_write), 32'd0);
        check("read_cycles", 32'(n_rd), 32'(exp_rd));
        check("write_cycles", 32'(n_wr), 32'(exp_wr));
        check("rw_overlap", 32'(n_ovl), 32'd0);
        check("mem_addr", 32'(n_badaddr), 32'd0);
        if (exp_wr == 1) begin
            check("wr_src", 32'(seen_src), 32'(exp_src));
            check("wr_data", seen_wd, exp_wd);
        end
        check("mem_word", mem[idx], ref_mem[idx]);

        @(posedge clk);
        #1;
        check("ack_pulse", 32'(ack), 32'd0);
        check("rdata_hold", rdata, exp_rdata_hold);
        check("err_hold", 32'(err), 32'(bad));
        check("mem_rw_in_idle", 32'(mem_read | mem_write), 32'd0);
    endtask

    initial begin
        int unsigned n_bad;
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; unsigned_ld = 1'b0;
        addr = 32'h0; wdata = 32'h0; exp_rdata_hold = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h8899_AABB;
        ref_mem[0] = 32'h8899_AABB;

        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_src", 32'(mem_write_data_src), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed scenarios on word 0x40.
        do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        check("ld_word_0x40", rdata, 32'h8899_AABB);
        do_req(1'b0, 2'd1, 1'b0, 32'h43, 32'h0);
        check("ld_byte_s", rdata, 32'hFFFF_FF88);
        do_req(1'b0, 2'd1, 1'b1, 32'h43, 32'h0);
        check("ld_byte_u", rdata, 32'h0000_0088);
        do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);
        check("ld_half_s", rdata, 32'hFFFF_8899);
        do_req(1'b1, 2'd2, 1'b0, 32'h42, 32'h0000_BEEF);
        check("rmw_half_mem", mem[0], RMW ? 32'hBEEF_AABB : 32'h8899_AABB);
        mem[0] = 32'h8899_AABB;
        ref_mem[0] = 32'h8899_AABB;
        do_req(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
        check("misaligned_ld_err", 32'(err), 32'd1);
        do_req(1'b1, 2'd1, 1'b0, 32'h40, 32'h1234_5678);
        check("st_byte_mem", mem[0], 32'h8899_AA78);

        // Reset in the middle of a load.
        req = 1'b1; we = 1'b0; size = 2'd0; addr = 32'h40;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_rd_before", 32'(mem_read), 32'd1);
        reset = 1'b0;
        exp_rdata_hold = 32'h0;
        #1;
        check("rst_mid_rd_drop", 32'(mem_read), 32'd0);
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        n_bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack || mem_read || mem_write) n_bad++;
        end
        check("rst_hold_quiet", 32'(n_bad), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0);
        check("ld_after_rst", rdata, 32'h8899_AA78);

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            int unsigned gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            #1;
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 3, giving the clock cycles mem_read is held before mem_read_data is sampled (covers the 7 ns memory read delay at a 2.5 ns clock).
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  core request strobe.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 word, 01 byte, 10 half; 11 reserved.
- unsigned_ld  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result.
- err  output  1  misalignment or reserved size; valid with ack.
- mem_addr  output  32  memory address, word-aligned (addr[1:0] forced to 00).
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_write_data  output  32  memory write data.
- mem_write_data_src  output  2  00 full word, 01 low byte [7:0], 10 low half [15:0].
- mem_read_data  input  32  memory read data.

Function
REQ-003 The FSM SHALL have states IDLE, RD, WR, RMW_RD, RMW_WR and DONE.
REQ-004 In IDLE, req=1 SHALL latch we, size, unsigned_ld, addr and wdata, then select the next state. When not in IDLE, req SHALL be ignored.
REQ-005 Byte lanes SHALL be little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
REQ-006 The following SHALL be errors: size 11; word with addr[1:0]!=0; half with addr[0]!=0.
- An error SHALL go IDLE->DONE with err=1.
- mem_read and mem_write SHALL never assert for that request.
REQ-007 A load SHALL go IDLE->RD.
- mem_read=1 for exactly READ_WAIT cycles.
- mem_read_data SHALL be captured on the last RD edge; then ->DONE.
REQ-008 rdata SHALL be the selected lane: word unchanged; half lane addr[1]; byte lane addr[1:0]. Sub-word results are zero- or sign-extended per unsigned_ld.
REQ-009 A store that is aligned in-lane SHALL go IDLE->WR, with mem_write=1 for exactly one cycle, then ->DONE:
- word: src 00, data = wdata.
- byte at offset 0: src 01.
- half at offset 0: src 10.
REQ-010 A byte store at offset 1-3 or a half store at offset 2 SHALL be handled per REQ-016.
REQ-011 In DONE, ack=1 for exactly one cycle, then ->IDLE. rdata and err SHALL hold their values until the next ack.
REQ-012 Latency from the req-sampling edge to ack high SHALL be:
- aligned store: 2 cycles.
- load: READ_WAIT+1 cycles.
- error: 1 cycle.
- RMW: READ_WAIT+2 cycles.
REQ-013 mem_read and mem_write SHALL never be high in the same cycle, and SHALL be 0 in IDLE and DONE.

Reset
REQ-014 reset=0 SHALL immediately (asynchronously) force:
- state = IDLE.
- ack, err, mem_read, mem_write = 0.
- rdata, mem_addr, mem_write_data = 0.
- mem_write_data_src = 00.
REQ-015 Reset asserted mid-operation SHALL abort the request with no ack and no further memory write. The first request is accepted on the first posedge after reset deasserts.

Configuration
REQ-016 Macro MAU_RMW_EN SHALL control misaligned sub-word stores.
- Defined: the store SHALL go RMW_RD (READ_WAIT cycles of mem_read, word captured) -> RMW_WR. RMW_WR asserts mem_write for one cycle, src 00, data = captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Then ->DONE.
- Undefined: the store SHALL be an error (err=1 in DONE, no memory access). States RMW_RD and RMW_WR SHALL not exist.

Verification
REQ-017 Load word: mem word 0x40 = 0x8899AABB; req load word addr 0x40 -> mem_read high 3 cycles, ack at cycle 4, rdata=0x8899AABB, err=0.
REQ-018 Sign vs zero extension on the same word: load byte addr 0x43 signed -> rdata=0xFFFFFF88; unsigned -> 0x00000088; load half addr 0x42 signed -> 0xFFFF8899.
REQ-019 Store byte wdata=0x12345678 addr 0x40 -> one mem_write cycle, src 01, mem_addr 0x40; memory becomes 0x8899AA78; ack at cycle 2.
REQ-020 With MAU_RMW_EN defined: store half 0xBEEF at addr 0x42 over 0x8899AABB -> read then write src 00 data 0xBEEFAABB, ack at cycle 5. Without the macro -> err=1, ack at cycle 1, memory unchanged.
REQ-021 Load word addr 0x41 -> err=1, ack at cycle 1, no mem_read.
REQ-022 Reset: reset=0 during cycle 2 of a load -> mem_read drops immediately, no ack; after release, a new load completes normally.
